byte_packer: RTL and testbench

Downstream drain stage for the 8-bit circular buffer. It pops bytes through the buffer's read_en/empty/data_out interface and packs LANES consecutive bytes into one wide word, first byte in the least-significant lane. It presents each word on a valid/ready output port to the wide datapath that follows.

---
 rtl/byte_packer_pkg.sv | 16 +
 rtl/byte_packer_timeout_ctr.sv | 36 +++
 rtl/byte_packer.sv | 123 ++++++++++++
 tb/tb_byte_packer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/byte_packer_pkg.sv
// byte_packer_pkg: shared constants for the byte packer drain stage.
// Holds default geometry (byte width, lanes, lane counter width, idle timeout)
// and the two FSM state codes {FILL, HOLD} as plain logic constants.
package byte_packer_pkg;

  localparam int DATA_W_DEF  = 8;   // byte width, matches the circular buffer
  localparam int LANES_DEF   = 4;   // bytes per output word
  localparam int LANE_W_DEF  = 3;   // log2(LANES)+1, holds 0..LANES
  localparam int TIMEOUT_DEF = 16;  // idle cycles before a partial flush
  localparam int TMO_W_DEF   = 5;   // idle counter width, holds TIMEOUT

  // FSM state codes
  localparam logic [0:0] ST_FILL = 1'b0;  // popping bytes into lanes
  localparam logic [0:0] ST_HOLD = 1'b1;  // word presented, waiting for handshake

endpackage

// File: rtl/byte_packer_timeout_ctr.sv
// pack_timeout_ctr: idle counter that requests a partial-word flush.
// Ports: clk, rst_n (async active-low), inc (idle this cycle), clr (activity),
//        expired (this edge completes TIMEOUT idle cycles).
// Only built when BYTE_PACKER_TIMEOUT_EN is defined.
`ifdef BYTE_PACKER_TIMEOUT_EN
module pack_timeout_ctr
  import byte_packer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TMO_W   = TMO_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  logic [TMO_W-1:0] r_cnt;

  // The counter would reach TIMEOUT on this edge: flag it now so the owner
  // changes state on the same edge, and restart from zero.
  assign expired = inc & ~clr & (r_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || expired) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + TMO_W'(1);
    end
  end

endmodule
`endif

// File: rtl/byte_packer.sv
// byte_packer: pops bytes from the 8-bit circular buffer and packs LANES of
// them (first byte in lane 0, the least-significant lane) into one wide word.
// Ports: clk, rst_n (async active-low); buf_empty/buf_data in, buf_read_en out
//        (buffer pop side, data valid the cycle after read_en);
//        out_data/out_bytes/out_valid out, out_ready in (valid/ready word port).
// Optional macro BYTE_PACKER_TIMEOUT_EN: flush a partial word after TIMEOUT
// idle cycles; without it only full LANES-byte words are emitted.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF
`ifdef BYTE_PACKER_TIMEOUT_EN
  ,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TMO_W   = TMO_W_DEF
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      buf_empty,
  input  logic [DATA_W-1:0]         buf_data,
  output logic                      buf_read_en,
  output logic [DATA_W*LANES-1:0]   out_data,
  output logic [LANE_W-1:0]         out_bytes,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [0:0]              r_state;
  logic [LANE_W-1:0]       r_lane_cnt;
  logic                    r_rd_pend;
  logic [DATA_W*LANES-1:0] r_out_data;
  logic [LANE_W-1:0]       r_out_bytes;

  logic                    w_fill;
  logic [LANE_W:0]         w_occupied;
  logic                    w_read_en;
  logic                    w_capture;
  logic                    w_last;
  logic                    w_flush;

  assign w_fill = (r_state == ST_FILL);

  // Lanes already written plus the byte still in flight; reads stop once this
  // covers every lane, so lane_cnt can never pass LANES.
  assign w_occupied = {1'b0, r_lane_cnt} + (LANE_W + 1)'(r_rd_pend);

  // Gated by rst_n so no pop is requested while reset is held.
  assign w_read_en = rst_n & w_fill & ~buf_empty &
                     (w_occupied < (LANE_W + 1)'(LANES));

  assign w_capture = w_fill & r_rd_pend;
  assign w_last    = w_capture & (r_lane_cnt == LANE_W'(LANES - 1));

`ifdef BYTE_PACKER_TIMEOUT_EN
  logic w_tmo_inc;
  logic w_tmo_clr;
  logic w_tmo_expired;

  // Idle: a partial word is waiting, nothing in flight, buffer has nothing.
  assign w_tmo_inc = w_fill & (r_lane_cnt != '0) & ~r_rd_pend & buf_empty;
  assign w_tmo_clr = ~w_fill | w_capture | (r_lane_cnt == '0);

  pack_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (w_tmo_inc),
    .clr     (w_tmo_clr),
    .expired (w_tmo_expired)
  );

  // A capture on the same edge wins over the flush.
  assign w_flush = w_tmo_expired & ~w_capture;
`else
  assign w_flush = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_FILL;
      r_lane_cnt  <= '0;
      r_rd_pend   <= 1'b0;
      r_out_data  <= '0;
      r_out_bytes <= '0;
    end else begin
      r_rd_pend <= w_read_en;
      if (w_fill) begin
        if (w_capture) begin
          for (int k = 0; k < LANES; k++) begin
            if (r_lane_cnt == LANE_W'(k)) begin
              r_out_data[k*DATA_W +: DATA_W] <= buf_data;
            end
          end
          r_lane_cnt <= r_lane_cnt + LANE_W'(1);
          if (w_last) begin
            r_state     <= ST_HOLD;
            r_out_bytes <= LANE_W'(LANES);
          end
        end else if (w_flush) begin
          r_state     <= ST_HOLD;
          r_out_bytes <= r_lane_cnt;
        end
      end else if (out_ready) begin
        // Handshake: clear lanes so a later partial word shows zeros above it.
        r_state     <= ST_FILL;
        r_lane_cnt  <= '0;
        r_out_data  <= '0;
        r_out_bytes <= '0;
      end
    end
  end

  assign buf_read_en = w_read_en;
  assign out_data    = r_out_data;
  assign out_bytes   = r_out_bytes;
  assign out_valid   = (r_state == ST_HOLD);

endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer: directed bench for byte_packer with a behavioural byte buffer,
// an expected-word queue filled by the stimulus and a monitor that pops and
// compares on every out_valid/out_ready handshake.
module tb_byte_packer;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        buf_empty;
  logic [7:0]  buf_data;
  logic        out_ready = 1'b0;
  logic        buf_read_en;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_valid;

  always #5 clk = ~clk;

  byte_packer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .buf_empty   (buf_empty),
    .buf_data    (buf_data),
    .buf_read_en (buf_read_en),
    .out_data    (out_data),
    .out_bytes   (out_bytes),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  int          total = 0;
  int          bad = 0;
  logic [7:0]  bq[$];
  logic [31:0] exp_d[$];
  logic [2:0]  exp_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [2:0] b);
    exp_d.push_back(d);
    exp_b.push_back(b);
  endtask

  // Buffer model: a pop requested in a cycle delivers data shortly after the
  // following edge; empty flag refreshed at the same point.
  initial begin : buf_model
    logic rd;
    buf_empty = 1'b1;
    buf_data  = 8'h00;
    forever begin
      @(posedge clk);
      rd = buf_read_en;
      #1;
      if (rd && bq.size() > 0) buf_data = bq.pop_front();
      buf_empty = (bq.size() == 0);
    end
  end

  task automatic monitor();
    forever begin
      @(negedge clk);
      #1;
      if (out_valid && out_ready) begin
        if (exp_d.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got 0x%08h expected none", out_data);
        end else begin
          check("word_data", out_data, exp_d.pop_front());
          check("word_bytes", 32'(out_bytes), 32'(exp_b.pop_front()));
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && exp_d.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check(name, exp_d.size(), 0);
  endtask

  initial begin : main
    int n_rd;
    int idx;
    int n;
    fork
      monitor();
    join_none

    // 1: reset held with a non-empty buffer
    rst_n     = 1'b0;
    out_ready = 1'b1;
    bq.push_back(8'h11); bq.push_back(8'h22); bq.push_back(8'h33); bq.push_back(8'h44);
    expect_word(32'h44332211, 3'd4);
    repeat (3) @(negedge clk);
    #1;
    check("rst_read_en", 32'(buf_read_en), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", out_data, 32'h0);
    check("rst_bytes", 32'(out_bytes), 0);

    // 2: four back-to-back pops, then one valid cycle
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_rd = 0;
    idx  = -1;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin
        idx = i;
        break;
      end
      if (buf_read_en) n_rd++;
      @(negedge clk);
      #1;
    end
    check("t2_reads", n_rd, 4);
    check("t2_valid_cycle", idx, 5);
    @(negedge clk);
    #1;
    check("t2_single_valid", 32'(out_valid), 0);
    wait_drain("t2_drain");

    // 3: backpressure holds the word stable and stops popping
    @(negedge clk);
    out_ready = 1'b0;
    for (int b = 1; b <= 8; b++) bq.push_back(8'(b));
    expect_word(32'h04030201, 3'd4);
    expect_word(32'h08070605, 3'd4);
    #1;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      @(negedge clk);
      #1;
    end
    check("t3_valid_seen", 32'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_data", out_data, 32'h04030201);
      check("t3_hold_rd", 32'(buf_read_en), 0);
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain("t3_drain");

    // 4: two bytes, then the buffer stays empty
    @(negedge clk);
    bq.push_back(8'hA1);
    bq.push_back(8'hB2);
`ifdef BYTE_PACKER_TIMEOUT_EN
    expect_word(32'h0000B2A1, 3'd2);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    check("t4_flush_cycle", n, TIMEOUT + 4);
`else
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) n++;
    end
    check("t4_no_partial", n, 0);
    @(negedge clk);
    bq.push_back(8'hC3);
    bq.push_back(8'hD4);
    expect_word(32'hD4C3B2A1, 3'd4);
`endif
    wait_drain("t4_drain");

    // 5: bytes separated by short empty gaps form one full word
    expect_word(32'h40302010, 3'd4);
    for (int b = 1; b <= 4; b++) begin
      @(negedge clk);
      bq.push_back(8'(b * 16));
      repeat (3) @(negedge clk);
    end
    wait_drain("t5_drain");

    // 6: reset pulse mid-word clears everything, next word has no stale lanes
    @(negedge clk);
    bq.push_back(8'h99); bq.push_back(8'hAA); bq.push_back(8'hBB);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_data", out_data, 32'h0);
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_read_en", 32'(buf_read_en), 0);
    check("t6_rst_bytes", 32'(out_bytes), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bq.push_back(8'h55); bq.push_back(8'h66); bq.push_back(8'h77); bq.push_back(8'h88);
    expect_word(32'h88776655, 3'd4);
    wait_drain("t6_drain");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
